// File: rtl/alu_mdu.sv
// Execute-stage ALU with a bit-serial multiply/divide unit. Base ops take 1 cycle; MUL*/DIV*/REM* take WORD_SIZE+1 cycles.
// Valid/ready on both sides; a held result (out_ready=0) stalls acceptance of the next operation.
module alu_mdu #(
  parameter int WORD_SIZE = 32,
  parameter int OP_WIDTH  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_WIDTH-1:0]  alu_op,
  input  logic [WORD_SIZE-1:0] arg1,
  input  logic [WORD_SIZE-1:0] arg2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] result,
  output logic                 zero,
  output logic                 busy
);

  localparam int SHW = $clog2(WORD_SIZE);
  localparam logic [WORD_SIZE-1:0] MIN_NEG = {1'b1, {(WORD_SIZE-1){1'b0}}};

  localparam logic [OP_WIDTH-1:0] OP_ADD    = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SUB    = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_AND    = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_OR     = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_XOR    = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_SLL    = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_SRL    = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_SRA    = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_SLT    = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_SLTU   = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] OP_MUL    = OP_WIDTH'(10);
  localparam logic [OP_WIDTH-1:0] OP_MULH   = OP_WIDTH'(11);
  localparam logic [OP_WIDTH-1:0] OP_MULHSU = OP_WIDTH'(12);
  localparam logic [OP_WIDTH-1:0] OP_MULHU  = OP_WIDTH'(13);
  localparam logic [OP_WIDTH-1:0] OP_DIV    = OP_WIDTH'(14);
  localparam logic [OP_WIDTH-1:0] OP_DIVU   = OP_WIDTH'(15);
  localparam logic [OP_WIDTH-1:0] OP_REM    = OP_WIDTH'(16);
  localparam logic [OP_WIDTH-1:0] OP_REMU   = OP_WIDTH'(17);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t               state;
  logic [WORD_SIZE:0]   acc_hi;
  logic [WORD_SIZE-1:0] acc_lo;
  logic [WORD_SIZE-1:0] opb;
  logic [SHW-1:0]       cnt;
  logic [OP_WIDTH-1:0]  op_q;
  logic                 sign_a_q;
  logic                 sign_b_q;
  logic [WORD_SIZE-1:0] result_q;
  logic                 zero_q;
  logic                 out_valid_q;
  logic                 busy_q;

  logic                 accept;
  logic                 is_mul, is_div, div_signed;
  logic                 sign_a, sign_b;
  logic [WORD_SIZE-1:0] a_mag, b_mag;
  logic                 div_zero, div_ovf, iter_start;
  logic [WORD_SIZE-1:0] single_res;
  logic [SHW-1:0]       shamt;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign zero      = zero_q;

  // Operand decode: signedness per op, magnitudes fed to the serial engine.
  always_comb begin
    is_mul     = (alu_op == OP_MUL) || (alu_op == OP_MULH) ||
                 (alu_op == OP_MULHSU) || (alu_op == OP_MULHU);
    is_div     = (alu_op == OP_DIV) || (alu_op == OP_DIVU) ||
                 (alu_op == OP_REM) || (alu_op == OP_REMU);
    div_signed = (alu_op == OP_DIV) || (alu_op == OP_REM);
    sign_a     = ((alu_op == OP_MULH) || (alu_op == OP_MULHSU) || div_signed) && arg1[WORD_SIZE-1];
    sign_b     = ((alu_op == OP_MULH) || div_signed) && arg2[WORD_SIZE-1];
    a_mag      = sign_a ? -arg1 : arg1;
    b_mag      = sign_b ? -arg2 : arg2;
    div_zero   = (arg2 == '0);
    div_ovf    = div_signed && (arg1 == MIN_NEG) && (arg2 == '1);
    iter_start = is_mul || (is_div && !div_zero && !div_ovf);
    shamt      = arg2[SHW-1:0];
  end

  always_comb begin
    single_res = '0;
    case (alu_op)
      OP_ADD:  single_res = arg1 + arg2;
      OP_SUB:  single_res = arg1 - arg2;
      OP_AND:  single_res = arg1 & arg2;
      OP_OR:   single_res = arg1 | arg2;
      OP_XOR:  single_res = arg1 ^ arg2;
      OP_SLL:  single_res = arg1 << shamt;
      OP_SRL:  single_res = arg1 >> shamt;
      OP_SRA:  single_res = $unsigned($signed(arg1) >>> shamt);
      OP_SLT:  single_res = {{(WORD_SIZE-1){1'b0}}, $signed(arg1) < $signed(arg2)};
      OP_SLTU: single_res = {{(WORD_SIZE-1){1'b0}}, arg1 < arg2};
      // Divide special cases never enter CALC.
      OP_DIV, OP_DIVU: single_res = div_zero ? '1 : arg1;
      OP_REM, OP_REMU: single_res = div_zero ? arg1 : '0;
      default: single_res = '0;
    endcase
  end

  logic                   q_is_mul;
  logic [WORD_SIZE:0]     mul_sum, div_shift, div_diff, hi_nxt;
  logic [WORD_SIZE-1:0]   lo_nxt;
  logic                   div_ge;
  logic [2*WORD_SIZE-1:0] prod, prod_fix;
  logic [WORD_SIZE-1:0]   quo_fix, rem_fix, final_res;

  // One shift-add or one restoring-divide step per CALC cycle.
  always_comb begin
    q_is_mul  = (op_q == OP_MUL) || (op_q == OP_MULH) ||
                (op_q == OP_MULHSU) || (op_q == OP_MULHU);
    mul_sum   = acc_hi + (acc_lo[0] ? {1'b0, opb} : '0);
    div_shift = {acc_hi[WORD_SIZE-1:0], acc_lo[WORD_SIZE-1]};
    div_diff  = div_shift - {1'b0, opb};
    div_ge    = !div_diff[WORD_SIZE];
    if (q_is_mul) begin
      hi_nxt = {1'b0, mul_sum[WORD_SIZE:1]};
      lo_nxt = {mul_sum[0], acc_lo[WORD_SIZE-1:1]};
    end else begin
      hi_nxt = div_ge ? div_diff : div_shift;
      lo_nxt = {acc_lo[WORD_SIZE-2:0], div_ge};
    end
    prod      = {hi_nxt[WORD_SIZE-1:0], lo_nxt};
    prod_fix  = (sign_a_q ^ sign_b_q) ? -prod : prod;
    quo_fix   = (sign_a_q ^ sign_b_q) ? -lo_nxt : lo_nxt;
    rem_fix   = sign_a_q ? -hi_nxt[WORD_SIZE-1:0] : hi_nxt[WORD_SIZE-1:0];
    case (op_q)
      OP_MUL:                       final_res = prod_fix[WORD_SIZE-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*WORD_SIZE-1:WORD_SIZE];
      OP_DIV, OP_DIVU:              final_res = quo_fix;
      default:                      final_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opb         <= '0;
      op_q        <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_q <= alu_op;
            if (iter_start) begin
              state       <= CALC;
              busy_q      <= 1'b1;
              out_valid_q <= 1'b0;
              cnt         <= '0;
              acc_hi      <= '0;
              acc_lo      <= is_mul ? b_mag : a_mag;
              opb         <= is_mul ? a_mag : b_mag;
              sign_a_q    <= sign_a;
              sign_b_q    <= sign_b;
            end else begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= single_res;
              zero_q      <= (single_res == '0);
            end
          end else if ((state == DONE) && out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        CALC: begin
          acc_hi <= hi_nxt;
          acc_lo <= lo_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == SHW'(WORD_SIZE-1)) begin
            state       <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            result_q    <= final_res;
            zero_q      <= (final_res == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: directed vector table, hand-written handshake/reset sequences, randomized ops vs reference model.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  alu_op;
  logic [31:0] arg1, arg2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  alu_mdu #(.WORD_SIZE(32), .OP_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .arg1(arg1), .arg2(arg2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model straight from the op definitions, using 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    r  = '0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4:  r = a ^ b;
      5'd5:  r = a << b[4:0];
      5'd6:  r = a >> b[4:0];
      5'd7:  r = $unsigned($signed(a) >>> b[4:0]);
      5'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
      5'd9:  r = (a < b) ? 32'd1 : 32'd0;
      5'd10: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      5'd11: begin p = sa * sb; r = p[63:32]; end
      5'd12: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
      5'd13: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      5'd14: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else begin p = sa / sb; r = p[31:0]; end
      end
      5'd15: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd16: begin
        if (b == 0) r = a;
        else begin p = sa % sb; r = p[31:0]; end
      end
      5'd17: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 5'd10 && op <= 5'd13) return 33;
    if (op >= 5'd14 && op <= 5'd17) begin
      if (b == 0) return 1;
      if ((op == 5'd14 || op == 5'd16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    return 1;
  endfunction

  // Issue one op from IDLE, wait (bounded) for the result, then retire it.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic z, output int lat, output int bcnt);
    int n;
    chk("in_ready_before_issue", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; alu_op = op; arg1 = a; arg2 = b; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n = 1; bcnt = 0;
    while (!out_valid && n < 100) begin
      bcnt += busy ? 1 : 0;
      step();
      n++;
    end
    r = result; z = zero; lat = n;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] r;
    logic        z;
    int          lat, bcnt, seen;
    logic [31:0] hold_r;
    logic        hold_z;

    rst = 1'b1; in_valid = 1'b0; alu_op = '0; arg1 = '0; arg2 = '0; out_ready = 1'b0;
    repeat (2) step();
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_zero", {31'b0, zero}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;
    step();

    vecs.push_back('{5'd0,  32'd7,          32'hFFFF_FFF9, 32'd0,          1});
    vecs.push_back('{5'd1,  32'd5,          32'd3,         32'd2,          1});
    vecs.push_back('{5'd2,  32'hF0F0_F0F0,  32'h0FF0_0FF0, 32'h00F0_00F0,  1});
    vecs.push_back('{5'd3,  32'hF000_0000,  32'h0000_000F, 32'hF000_000F,  1});
    vecs.push_back('{5'd4,  32'hAAAA_AAAA,  32'hFFFF_FFFF, 32'h5555_5555,  1});
    vecs.push_back('{5'd5,  32'h0000_0001,  32'h0000_0021, 32'h0000_0002,  1});
    vecs.push_back('{5'd6,  32'h8000_0000,  32'h0000_001F, 32'h0000_0001,  1});
    vecs.push_back('{5'd7,  32'h8000_0000,  32'h0000_0024, 32'hF800_0000,  1});
    vecs.push_back('{5'd9,  32'd1,          32'hFFFF_FFFF, 32'd1,          1});
    vecs.push_back('{5'd8,  32'd1,          32'hFFFF_FFFF, 32'd0,          1});
    vecs.push_back('{5'd10, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 33});
    vecs.push_back('{5'd13, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    vecs.push_back('{5'd11, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33});
    vecs.push_back('{5'd12, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
    vecs.push_back('{5'd14, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33});
    vecs.push_back('{5'd16, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33});
    vecs.push_back('{5'd15, 32'd100,        32'd7,         32'd14,        33});
    vecs.push_back('{5'd17, 32'd100,        32'd7,         32'd2,         33});
    vecs.push_back('{5'd14, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF,  1});
    vecs.push_back('{5'd17, 32'h1234_5678,  32'd0,         32'h1234_5678,  1});
    vecs.push_back('{5'd14, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000,  1});
    vecs.push_back('{5'd16, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000,  1});
    vecs.push_back('{5'd20, 32'd5,          32'd6,         32'h0000_0000,  1});

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, lat, bcnt);
      chk($sformatf("vec%0d_result", i), r, vecs[i].exp);
      chk($sformatf("vec%0d_zero", i), {31'b0, z}, {31'b0, vecs[i].exp == 0});
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, (vecs[i].lat == 33) ? 32 : 0);
    end

    // Back-to-back single-cycle ops with out_ready held high.
    in_valid = 1'b1; alu_op = 5'd0; arg1 = 32'd7; arg2 = 32'hFFFF_FFF9; out_ready = 1'b0;
    step();
    chk("b2b_add_valid", {31'b0, out_valid}, 32'd1);
    chk("b2b_add_zero", {31'b0, zero}, 32'd1);
    alu_op = 5'd1; arg1 = 32'd5; arg2 = 32'd3; out_ready = 1'b1;
    #1;
    chk("b2b_in_ready_done", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("b2b_sub_valid", {31'b0, out_valid}, 32'd1);
    chk("b2b_sub_result", result, 32'd2);
    chk("b2b_sub_zero", {31'b0, zero}, 32'd0);
    step();
    chk("b2b_retired", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Backpressure: result held for 5 cycles while out_ready is low.
    in_valid = 1'b1; alu_op = 5'd15; arg1 = 32'd100; arg2 = 32'd7;
    step();
    in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 100) begin step(); seen++; end
    hold_r = result; hold_z = zero;
    chk("bp_result", hold_r, 32'd14);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; alu_op = 5'd0; arg1 = 32'd1; arg2 = 32'd1;
      #1;
      chk($sformatf("bp_in_ready_c%0d", k), {31'b0, in_ready}, 32'd0);
      step();
      chk($sformatf("bp_valid_c%0d", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp_stable_c%0d", k), result, hold_r);
      chk($sformatf("bp_zero_c%0d", k), {31'b0, zero}, {31'b0, hold_z});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);

    // Reset in CALC cycle 10 aborts the multiply with no output.
    in_valid = 1'b1; alu_op = 5'd10; arg1 = 32'd3; arg2 = 32'd5;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    chk("abort_busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_result", result, 32'd0);
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      seen += out_valid ? 1 : 0;
      step();
    end
    chk("abort_no_output", seen, 0);
    out_ready = 1'b0;

    // Randomized ops against the reference model.
    for (int t = 0; t < 150; t++) begin
      logic [4:0]  op;
      logic [31:0] a, b;
      op = (t % 10 == 9) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
      case ($urandom_range(0, 5))
        0: a = 32'd0;
        1: a = 32'h8000_0000;
        2: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 40));
        default: b = $urandom;
      endcase
      run_op(op, a, b, r, z, lat, bcnt);
      chk($sformatf("rnd%0d_op%0d_result", t, op), r, model(op, a, b));
      chk($sformatf("rnd%0d_op%0d_zero", t, op), {31'b0, z}, {31'b0, model(op, a, b) == 0});
      chk($sformatf("rnd%0d_op%0d_latency", t, op), lat, model_lat(op, a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
